// File: rtl/execute_stage.sv
// Execute stage: forwarded operand selection, single-cycle ALU, iterative shift-add
// multiply, and the registered execute/memory boundary (_M outputs).
module execute_stage #(
  parameter int N = 32,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         regw_E,
  input  logic         memw_E,
  input  logic         regmem_E,
  input  logic         ALUope_E,
  input  logic [M-1:0] ALUctrl_E,
  input  logic [M-1:0] regScr_E,
  input  logic [N-1:0] regA_E,
  input  logic [N-1:0] regB_E,
  input  logic [N-1:0] inm_E,
  input  logic [1:0]   fwdA_E,
  input  logic [1:0]   fwdB_E,
  input  logic [N-1:0] result_W,
  output logic         stall_E,
  output logic         regw_M,
  output logic         memw_M,
  output logic         regmem_M,
  output logic [M-1:0] regScr_M,
  output logic [N-1:0] ALUout_M,
  output logic [N-1:0] wdata_M,
  output logic [3:0]   flags_M
);

  localparam int SW = $clog2(N);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [M-1:0] OP_ADD = M'(0);
  localparam logic [M-1:0] OP_SUB = M'(1);
  localparam logic [M-1:0] OP_AND = M'(2);
  localparam logic [M-1:0] OP_OR  = M'(3);
  localparam logic [M-1:0] OP_XOR = M'(4);
  localparam logic [M-1:0] OP_SLL = M'(5);
  localparam logic [M-1:0] OP_SRL = M'(6);
  localparam logic [M-1:0] OP_SRA = M'(7);
  localparam logic [M-1:0] OP_MOV = M'(8);
  localparam logic [M-1:0] OP_MUL = M'(9);

  // Returns {N, Z, C, V, result}. C and V are meaningful only for ADD/SUB.
  function automatic logic [N+3:0] alu_op(input logic [M-1:0] op,
                                          input logic [N-1:0] a,
                                          input logic [N-1:0] b);
    logic [N:0]          sum;
    logic [N-1:0]        r;
    logic signed [N-1:0] a_s;
    logic [SW-1:0]       sh;
    logic                c;
    logic                v;
    sum = '0;
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    a_s = a;
    sh  = b[SW-1:0];
    case (op)
      OP_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        r   = sum[N-1:0];
        c   = sum[N];
        v   = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
      end
      OP_SUB: begin
        sum = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
        r   = sum[N-1:0];
        c   = sum[N];
        v   = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << sh;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = a_s >>> sh;
      OP_MOV:  r = b;
      default: r = '0;
    endcase
    return {r[N-1], (r == '0), c, v, r};
  endfunction

  logic [N-1:0]  op_a;
  logic [N-1:0]  op_bf;
  logic [N-1:0]  op_b;
  logic [N+3:0]  alu_res;
  logic [N-1:0]  prod_next;
  logic          mul_start;
  logic          mul_last;

  logic [0:0]    state_p1;
  logic [SW-1:0] cnt_p1;
  logic [N-1:0]  mcand_p1;
  logic [N-1:0]  mplier_p1;
  logic [N-1:0]  acc_p1;
  logic          regw_p1;
  logic          memw_p1;
  logic          regmem_p1;
  logic [M-1:0]  scr_p1;
  logic [N-1:0]  wdata_p1;

  // ---- stage E: operand selection and combinational execute ----
  always_comb begin
    case (fwdA_E)
      2'b01:   op_a = ALUout_M;
      2'b10:   op_a = result_W;
      default: op_a = regA_E;
    endcase
    case (fwdB_E)
      2'b01:   op_bf = ALUout_M;
      2'b10:   op_bf = result_W;
      default: op_bf = regB_E;
    endcase
    op_b = ALUope_E ? inm_E : op_bf;
  end

  assign alu_res   = alu_op(ALUctrl_E, op_a, op_b);
  assign prod_next = acc_p1 + (mplier_p1[0] ? mcand_p1 : '0);
  assign mul_start = (state_p1 == S_IDLE) && (ALUctrl_E == OP_MUL);
  assign mul_last  = (state_p1 == S_BUSY) && (cnt_p1 == SW'(N - 1));
  // Reset forces stall low even if a MUL code sits on the E inputs.
  assign stall_E   = ~rst & (mul_start | ((state_p1 == S_BUSY) & ~mul_last));

  // ---- stage E -> M boundary: multiply state and registered outputs ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p1  <= S_IDLE;
      cnt_p1    <= '0;
      mcand_p1  <= '0;
      mplier_p1 <= '0;
      acc_p1    <= '0;
      regw_p1   <= 1'b0;
      memw_p1   <= 1'b0;
      regmem_p1 <= 1'b0;
      scr_p1    <= '0;
      wdata_p1  <= '0;
      regw_M    <= 1'b0;
      memw_M    <= 1'b0;
      regmem_M  <= 1'b0;
      regScr_M  <= '0;
      ALUout_M  <= '0;
      wdata_M   <= '0;
      flags_M   <= '0;
    end else if (state_p1 == S_IDLE) begin
      if (mul_start) begin
        state_p1  <= S_BUSY;
        cnt_p1    <= '0;
        mcand_p1  <= op_a;
        mplier_p1 <= op_b;
        acc_p1    <= '0;
        regw_p1   <= regw_E;
        memw_p1   <= memw_E;
        regmem_p1 <= regmem_E;
        scr_p1    <= regScr_E;
        wdata_p1  <= op_bf;
        regw_M    <= 1'b0;
        memw_M    <= 1'b0;
        regmem_M  <= 1'b0;
        regScr_M  <= '0;
        ALUout_M  <= '0;
        wdata_M   <= '0;
        flags_M   <= '0;
      end else begin
        regw_M    <= regw_E;
        memw_M    <= memw_E;
        regmem_M  <= regmem_E;
        regScr_M  <= regScr_E;
        ALUout_M  <= alu_res[N-1:0];
        wdata_M   <= op_bf;
        flags_M   <= alu_res[N+3:N];
      end
    end else begin
      // One partial product per cycle; bit k of the multiplier is consumed at count k.
      acc_p1    <= prod_next;
      mcand_p1  <= mcand_p1 << 1;
      mplier_p1 <= mplier_p1 >> 1;
      cnt_p1    <= cnt_p1 + SW'(1);
      if (mul_last) begin
        state_p1  <= S_IDLE;
        regw_M    <= regw_p1;
        memw_M    <= memw_p1;
        regmem_M  <= regmem_p1;
        regScr_M  <= scr_p1;
        ALUout_M  <= prod_next;
        wdata_M   <= wdata_p1;
        flags_M   <= {prod_next[N-1], (prod_next == '0), 2'b00};
      end else begin
        regw_M    <= 1'b0;
        memw_M    <= 1'b0;
        regmem_M  <= 1'b0;
        regScr_M  <= '0;
        ALUout_M  <= '0;
        wdata_M   <= '0;
        flags_M   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: the driver queues per-cycle expectations,
// the monitor pops one each falling edge and compares stall_E and the _M outputs.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        regw_E, memw_E, regmem_E, ALUope_E;
  logic [3:0]  ALUctrl_E, regScr_E;
  logic [31:0] regA_E, regB_E, inm_E, result_W;
  logic [1:0]  fwdA_E, fwdB_E;
  logic        stall_E, regw_M, memw_M, regmem_M;
  logic [3:0]  regScr_M, flags_M;
  logic [31:0] ALUout_M, wdata_M;

  execute_stage #(.N(32), .M(4)) dut (
    .clk(clk), .rst(rst),
    .regw_E(regw_E), .memw_E(memw_E), .regmem_E(regmem_E), .ALUope_E(ALUope_E),
    .ALUctrl_E(ALUctrl_E), .regScr_E(regScr_E),
    .regA_E(regA_E), .regB_E(regB_E), .inm_E(inm_E),
    .fwdA_E(fwdA_E), .fwdB_E(fwdB_E), .result_W(result_W),
    .stall_E(stall_E), .regw_M(regw_M), .memw_M(memw_M), .regmem_M(regmem_M),
    .regScr_M(regScr_M), .ALUout_M(ALUout_M), .wdata_M(wdata_M), .flags_M(flags_M)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic        regw;
    logic        memw;
    logic        regmem;
    logic [3:0]  scr;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [3:0]  flags;
    logic        chk_wd;
  } exp_t;

  exp_t q[$];
  exp_t nxt;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int cyc, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, want);
    end
  endtask

  // Monitor: each falling edge, compare the current outputs with the oldest expectation.
  initial begin
    exp_t e;
    int   cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        cyc++;
        chk("stall_E", cyc, {31'b0, stall_E}, {31'b0, e.stall});
        chk("ctrl_M", cyc, {25'b0, regw_M, memw_M, regmem_M, regScr_M},
            {25'b0, e.regw, e.memw, e.regmem, e.scr});
        chk("ALUout_M", cyc, ALUout_M, e.alu);
        chk("flags_M", cyc, {28'b0, flags_M}, {28'b0, e.flags});
        if (e.chk_wd) chk("wdata_M", cyc, wdata_M, e.wdata);
      end
    end
  end

  task automatic set_ins(input logic [3:0] op, input logic rw, input logic mw,
                         input logic rm, input logic [3:0] scr, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] im, input logic [1:0] fa,
                         input logic [1:0] fb, input logic ope, input logic [31:0] rwb);
    ALUctrl_E = op; regw_E = rw; memw_E = mw; regmem_E = rm; regScr_E = scr;
    regA_E = a; regB_E = b; inm_E = im; fwdA_E = fa; fwdB_E = fb;
    ALUope_E = ope; result_W = rwb;
  endtask

  // Push this cycle's expectation (stall now, _M as loaded by the previous edge),
  // then record what the coming edge must load, and advance one cycle.
  task automatic step(input logic st, input logic rw, input logic mw, input logic rm,
                      input logic [3:0] scr, input logic [31:0] alu, input logic [31:0] wd,
                      input logic [3:0] fl, input logic cwd);
    exp_t e;
    e = nxt;
    e.stall = st;
    q.push_back(e);
    nxt = '{stall: 1'b0, regw: rw, memw: mw, regmem: rm, scr: scr, alu: alu,
            wdata: wd, flags: fl, chk_wd: cwd};
    @(posedge clk);
    #1;
  endtask

  task automatic bubble(input logic st);
    step(st, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1);
  endtask

  task automatic garbage();
    set_ins(4'd0, 1'b1, 1'b1, 1'b1, 4'hF, 32'hDEAD, 32'hBEEF, 32'h1, 2'b01, 2'b10, 1'b0, 32'h55);
  endtask

  // Full multiply: capture cycle plus N BUSY cycles with junk on the E inputs.
  task automatic mul_seq(input logic [31:0] a, input logic [31:0] b, input logic ope,
                         input logic rw, input logic [3:0] scr, input logic [31:0] prod,
                         input logic [3:0] fl);
    set_ins(4'd9, rw, 1'b0, 1'b0, scr, a, 32'h0, b, 2'b00, 2'b00, 1'b1, 32'h0);
    if (!ope) begin
      regB_E = b;
      ALUope_E = 1'b0;
      inm_E = 32'h1234;
    end
    bubble(1'b1);
    for (int i = 0; i < 31; i++) begin
      garbage();
      bubble(1'b1);
    end
    garbage();
    step(1'b0, rw, 1'b0, 1'b0, scr, prod, 32'd0, fl, 1'b0);
  endtask

  initial begin
    nxt = '0;
    rst = 1'b1;
    set_ins(4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 32'd0);
    @(posedge clk);
    #1;
    bubble(1'b0);
    rst = 1'b0;

    // ALU operations and flags
    set_ins(4'd0, 1, 0, 0, 4'd3, 32'd5, 32'd7, 32'd0, 2'b00, 2'b00, 0, 32'd0);
    step(0, 1, 0, 0, 4'd3, 32'd12, 32'd7, 4'b0000, 1);
    set_ins(4'd1, 0, 1, 0, 4'd4, 32'd3, 32'd5, 32'd0, 2'b00, 2'b00, 0, 32'd0);
    step(0, 0, 1, 0, 4'd4, 32'hFFFFFFFE, 32'd5, 4'b1000, 1);
    set_ins(4'd0, 1, 0, 1, 4'd5, 32'h7FFFFFFF, 32'h55, 32'd1, 2'b00, 2'b00, 1, 32'd0);
    step(0, 1, 0, 1, 4'd5, 32'h80000000, 32'h55, 4'b1001, 1);
    set_ins(4'd0, 1, 0, 0, 4'd6, 32'hFFFFFFFF, 32'd1, 32'd0, 2'b00, 2'b00, 0, 32'd0);
    step(0, 1, 0, 0, 4'd6, 32'd0, 32'd1, 4'b0110, 1);
    set_ins(4'd1, 1, 0, 0, 4'd7, 32'd5, 32'd5, 32'd0, 2'b00, 2'b00, 0, 32'd0);
    step(0, 1, 0, 0, 4'd7, 32'd0, 32'd5, 4'b0110, 1);
    set_ins(4'd2, 1, 0, 0, 4'd8, 32'hF0F0, 32'hFF00, 32'd0, 2'b00, 2'b00, 0, 32'd0);
    step(0, 1, 0, 0, 4'd8, 32'hF000, 32'hFF00, 4'b0000, 1);
    set_ins(4'd3, 1, 0, 0, 4'd9, 32'hF0F0, 32'h0F0F, 32'd0, 2'b00, 2'b00, 0, 32'd0);
    step(0, 1, 0, 0, 4'd9, 32'hFFFF, 32'h0F0F, 4'b0000, 1);
    set_ins(4'd4, 1, 0, 0, 4'd10, 32'hFF, 32'h0F, 32'd0, 2'b00, 2'b00, 0, 32'd0);
    step(0, 1, 0, 0, 4'd10, 32'hF0, 32'h0F, 4'b0000, 1);

    // Reset with a MUL on the inputs clears _M and holds stall low
    set_ins(4'd9, 1, 0, 0, 4'd2, 32'd3, 32'd3, 32'd0, 2'b00, 2'b00, 0, 32'd0);
    rst = 1'b1;
    nxt = '0;
    bubble(1'b0);
    rst = 1'b0;

    // Forwarding paths
    set_ins(4'd8, 1, 0, 0, 4'd1, 32'd0, 32'd0, 32'd100, 2'b00, 2'b00, 1, 32'd0);
    step(0, 1, 0, 0, 4'd1, 32'd100, 32'd0, 4'b0000, 1);
    set_ins(4'd0, 1, 0, 0, 4'd2, 32'd7, 32'd8, 32'd0, 2'b01, 2'b10, 0, 32'd23);
    step(0, 1, 0, 0, 4'd2, 32'd123, 32'd23, 4'b0000, 1);
    set_ins(4'd5, 1, 0, 0, 4'd3, 32'd7, 32'd9, 32'd4, 2'b10, 2'b00, 1, 32'd100);
    step(0, 1, 0, 0, 4'd3, 32'd1600, 32'd9, 4'b0000, 1);
    set_ins(4'd0, 1, 0, 0, 4'd4, 32'd10, 32'd20, 32'd0, 2'b11, 2'b11, 0, 32'd999);
    step(0, 1, 0, 0, 4'd4, 32'd30, 32'd20, 4'b0000, 1);

    // Shifts, MOV, undefined opcode
    set_ins(4'd7, 1, 0, 0, 4'd5, 32'h80000000, 32'd3, 32'd4, 2'b00, 2'b00, 1, 32'd0);
    step(0, 1, 0, 0, 4'd5, 32'hF8000000, 32'd3, 4'b1000, 1);
    set_ins(4'd6, 1, 0, 0, 4'd5, 32'h80000000, 32'd3, 32'd4, 2'b00, 2'b00, 1, 32'd0);
    step(0, 1, 0, 0, 4'd5, 32'h08000000, 32'd3, 4'b0000, 1);
    set_ins(4'd12, 1, 0, 0, 4'd6, 32'd5, 32'd6, 32'd0, 2'b00, 2'b00, 0, 32'd0);
    step(0, 1, 0, 0, 4'd6, 32'd0, 32'd6, 4'b0100, 1);
    set_ins(4'd8, 1, 0, 0, 4'd7, 32'd5, 32'h80000001, 32'd0, 2'b00, 2'b00, 0, 32'd0);
    step(0, 1, 0, 0, 4'd7, 32'h80000001, 32'h80000001, 4'b1000, 1);

    // Multiplies
    mul_seq(32'd1234, 32'd5678, 1'b0, 1'b1, 4'd9, 32'd7006652, 4'b0000);
    set_ins(4'd0, 1, 0, 0, 4'd1, 32'd1, 32'd1, 32'd0, 2'b00, 2'b00, 0, 32'd0);
    step(0, 1, 0, 0, 4'd1, 32'd2, 32'd1, 4'b0000, 1);
    mul_seq(32'hFFFFFFFF, 32'd3, 1'b1, 1'b1, 4'd11, 32'hFFFFFFFD, 4'b1000);
    mul_seq(32'd0, 32'd77, 1'b0, 1'b0, 4'd12, 32'd0, 4'b0100);

    // Reset in BUSY cycle 10 aborts the multiply
    set_ins(4'd9, 1, 0, 0, 4'd13, 32'd1234, 32'd5678, 32'd0, 2'b00, 2'b00, 0, 32'd0);
    bubble(1'b1);
    for (int i = 0; i < 10; i++) begin
      garbage();
      bubble(1'b1);
    end
    rst = 1'b1;
    nxt = '0;
    bubble(1'b0);
    bubble(1'b0);
    rst = 1'b0;
    set_ins(4'd0, 1, 0, 0, 4'd1, 32'd2, 32'd2, 32'd0, 2'b00, 2'b00, 0, 32'd0);
    step(0, 1, 0, 0, 4'd1, 32'd4, 32'd2, 4'b0000, 1);
    set_ins(4'd8, 0, 0, 0, 4'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1, 32'd0);
    step(0, 0, 0, 0, 4'd0, 32'd0, 32'd0, 4'b0100, 1);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
